// File: rtl/uart_rx_frame.sv
// UART receiver with configurable data width, parity and stop bits.
// Samples mid-bit and delivers frames over valid/ack with error and overrun flags.
module uart_rx_frame #(
    parameter int unsigned CLK_PER_BIT = 100,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_line,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ack,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_sync1, r_sync2;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_ferr_acc, w_ferr_nxt;
    logic                 r_perr_acc, w_perr_nxt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_ferr, r_perr, r_ovr, r_busy;
    logic                 w_rx_s, w_half, w_full, w_deliver, w_par_x;

    assign w_rx_s  = r_sync2;
    assign w_half  = (r_cnt == HALF_M1);
    assign w_full  = (r_cnt == FULL_M1);
    assign w_par_x = (^r_shift) ^ w_rx_s;

    // Next-state and frame datapath
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_ferr_nxt  = r_ferr_acc;
        w_perr_nxt  = r_perr_acc;
        w_deliver   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_idx_nxt   = '0;
                    w_ferr_nxt  = 1'b0;
                    w_perr_nxt  = 1'b0;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_idx == LAST_DATA) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (w_full) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_perr_nxt  = (PARITY == 1) ? ~w_par_x : w_par_x;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_full) begin
                    w_cnt_nxt  = '0;
                    w_ferr_nxt = r_ferr_acc | ~w_rx_s;
                    if (r_idx == LAST_STOP) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, synchronizer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_ferr_acc <= 1'b0;
            r_perr_acc <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_ovr      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sync1    <= serial_line;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_ferr_acc <= w_ferr_nxt;
            r_perr_acc <= w_perr_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_deliver) begin
                r_data  <= r_shift;
                r_ferr  <= w_ferr_nxt;
                r_perr  <= r_perr_acc;
                r_valid <= 1'b1;
                if (r_valid && !ack) r_ovr <= 1'b1;
            end else if (r_valid && ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign framing_err = r_ferr;
    assign parity_err  = r_perr;
    assign overrun     = r_ovr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: four configurations (8N1, 7E1, 7O1, 8N2) checked
// against a frame scoreboard plus direct checks of glitch, overrun and reset.
module tb_uart_rx_frame;

    localparam int CPB = 16;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       fe;
        logic       pe;
        logic       ov;
        int         t0;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] rx_line, ack, ack_edge;
    logic [7:0] d0, d3;
    logic [6:0] d1, d2;
    logic [3:0] m_valid, m_ferr, m_perr, m_ovr, m_busy;
    logic [8:0] m_data [4];
    logic [3:0] p_valid, p_ovr;
    logic [8:0] p_data [4];
    exp_t       sb_q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    assign m_data[0] = {1'b0, d0};
    assign m_data[1] = {2'b0, d1};
    assign m_data[2] = {2'b0, d2};
    assign m_data[3] = {1'b0, d3};

    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .serial_line(rx_line[0]), .data(d0), .valid(m_valid[0]),
        .ack(ack[0]), .framing_err(m_ferr[0]), .parity_err(m_perr[0]), .overrun(m_ovr[0]),
        .busy(m_busy[0]));
    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst_n(rst_n), .serial_line(rx_line[1]), .data(d1), .valid(m_valid[1]),
        .ack(ack[1]), .framing_err(m_ferr[1]), .parity_err(m_perr[1]), .overrun(m_ovr[1]),
        .busy(m_busy[1]));
    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
        .clk(clk), .rst_n(rst_n), .serial_line(rx_line[2]), .data(d2), .valid(m_valid[2]),
        .ack(ack[2]), .framing_err(m_ferr[2]), .parity_err(m_perr[2]), .overrun(m_ovr[2]),
        .busy(m_busy[2]));
    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .serial_line(rx_line[3]), .data(d3), .valid(m_valid[3]),
        .ack(ack[3]), .framing_err(m_ferr[3]), .parity_err(m_perr[3]), .overrun(m_ovr[3]),
        .busy(m_busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        ack_edge = ack;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int nbits, input int has_par, input int nstop);
        return 3 + CPB / 2 + (nbits + has_par + nstop) * CPB;
    endfunction

    task automatic push_exp(input int inst, input logic [8:0] d, input logic fe,
                            input logic pe, input logic ov, input int lat);
        exp_t e;
        e.inst = inst; e.data = d; e.fe = fe; e.pe = pe; e.ov = ov;
        e.t0 = cyc; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; the line keeps the last stop value on return.
    task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                              input logic has_par, input logic pbit,
                              input logic [1:0] stops, input int nstop);
        rx_line[inst] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx_line[inst] = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (has_par) begin
            rx_line[inst] = pbit;
            repeat (CPB) @(negedge clk);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_line[inst] = stops[s];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Frame monitor: a delivery is valid rising, valid held across an ack,
    // or an unacknowledged frame being replaced.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                p_valid[i] = 1'b0;
                p_ovr[i]   = 1'b0;
                p_data[i]  = '0;
            end else begin
                if (m_valid[i] && (!p_valid[i] || ack_edge[i] || m_data[i] != p_data[i] ||
                                   (m_ovr[i] && !p_ovr[i]))) begin
                    if (sb_q.size() == 0) begin
                        check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check_val("frame_inst", 32'(i), 32'(e.inst));
                        check_val("frame_data", 32'(m_data[i]), 32'(e.data));
                        check_val("frame_ferr", 32'(m_ferr[i]), 32'(e.fe));
                        check_val("frame_perr", 32'(m_perr[i]), 32'(e.pe));
                        check_val("frame_ovr", 32'(m_ovr[i]), 32'(e.ov));
                        check_val("frame_latency", 32'(cyc - e.t0), 32'(e.lat));
                    end
                end
                p_valid[i] = m_valid[i];
                p_ovr[i]   = m_ovr[i];
                p_data[i]  = m_data[i];
            end
        end
    end

    initial begin
        logic seen;
        rst_n   = 1'b0;
        rx_line = '1;
        ack     = '1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_val("rst_data", 32'(m_data[i]), 32'd0);
            check_val("rst_valid", 32'(m_valid[i]), 32'd0);
            check_val("rst_busy", 32'(m_busy[i]), 32'd0);
            check_val("rst_flags", 32'({m_ferr[i], m_perr[i], m_ovr[i]}), 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 sweep, back-to-back frames, ack held high
        for (int k = 0; k < 256; k++) begin
            push_exp(0, 9'(k), 1'b0, 1'b0, 1'b0, lat_of(8, 0, 1));
            send_frame(0, 9'(k), 8, 1'b0, 1'b0, 2'b11, 1);
        end
        repeat (2 * CPB) @(negedge clk);

        // Glitch: 3 clocks low
        seen = 1'b0;
        rx_line[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (2 * CPB) begin
            @(negedge clk);
            if (m_busy[0]) seen = 1'b1;
        end
        check_val("glitch_busy_seen", 32'(seen), 32'd1);
        check_val("glitch_idle", 32'(m_busy[0]), 32'd0);
        check_val("glitch_valid", 32'(m_valid[0]), 32'd0);
        check_val("glitch_data", 32'(m_data[0]), 32'hFF);

        // Overrun with ack low
        ack[0] = 1'b0;
        push_exp(0, 9'h11, 1'b0, 1'b0, 1'b0, lat_of(8, 0, 1));
        send_frame(0, 9'h11, 8, 1'b0, 1'b0, 2'b11, 1);
        push_exp(0, 9'h22, 1'b0, 1'b0, 1'b1, lat_of(8, 0, 1));
        send_frame(0, 9'h22, 8, 1'b0, 1'b0, 2'b11, 1);
        repeat (4) @(negedge clk);
        check_val("ovr_valid", 32'(m_valid[0]), 32'd1);
        check_val("ovr_flag", 32'(m_ovr[0]), 32'd1);
        check_val("ovr_data", 32'(m_data[0]), 32'h22);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        check_val("ack_valid_clr", 32'(m_valid[0]), 32'd0);
        check_val("ack_ovr_clr", 32'(m_ovr[0]), 32'd0);
        check_val("ack_data_hold", 32'(m_data[0]), 32'h22);

        // Ack coinciding with the second delivery
        push_exp(0, 9'h33, 1'b0, 1'b0, 1'b0, lat_of(8, 0, 1));
        send_frame(0, 9'h33, 8, 1'b0, 1'b0, 2'b11, 1);
        push_exp(0, 9'h44, 1'b0, 1'b0, 1'b0, lat_of(8, 0, 1));
        fork
            send_frame(0, 9'h44, 8, 1'b0, 1'b0, 2'b11, 1);
            begin
                repeat (lat_of(8, 0, 1) - 1) @(negedge clk);
                ack[0] = 1'b1;
                @(negedge clk);
                ack[0] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check_val("coin_valid", 32'(m_valid[0]), 32'd1);
        check_val("coin_ovr", 32'(m_ovr[0]), 32'd0);
        check_val("coin_data", 32'(m_data[0]), 32'h44);
        ack[0] = 1'b1;
        @(negedge clk);
        check_val("coin_ack_clr", 32'(m_valid[0]), 32'd0);

        // Async reset in the middle of the data bits of 0x3C
        fork
            send_frame(0, 9'h3C, 8, 1'b0, 1'b0, 2'b11, 1);
            begin
                repeat (3 + CPB / 2 + 4 * CPB) @(negedge clk);
                check_val("pre_rst_busy", 32'(m_busy[0]), 32'd1);
                rst_n = 1'b0;
                #1;
                check_val("arst_data", 32'(m_data[0]), 32'd0);
                check_val("arst_valid", 32'(m_valid[0]), 32'd0);
                check_val("arst_busy", 32'(m_busy[0]), 32'd0);
                check_val("arst_flags", 32'({m_ferr[0], m_perr[0], m_ovr[0]}), 32'd0);
            end
        join
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(0, 9'hC3, 1'b0, 1'b0, 1'b0, lat_of(8, 0, 1));
        send_frame(0, 9'hC3, 8, 1'b0, 1'b0, 2'b11, 1);
        repeat (2 * CPB) @(negedge clk);

        // 7E1 / 7O1: 0x55 has four ones, so parity bit 0 is even-correct
        push_exp(1, 9'h55, 1'b0, 1'b0, 1'b0, lat_of(7, 1, 1));
        send_frame(1, 9'h55, 7, 1'b1, 1'b0, 2'b11, 1);
        push_exp(1, 9'h55, 1'b0, 1'b1, 1'b0, lat_of(7, 1, 1));
        send_frame(1, 9'h55, 7, 1'b1, 1'b1, 2'b11, 1);
        push_exp(2, 9'h55, 1'b0, 1'b1, 1'b0, lat_of(7, 1, 1));
        send_frame(2, 9'h55, 7, 1'b1, 1'b0, 2'b11, 1);
        push_exp(2, 9'h55, 1'b0, 1'b0, 1'b0, lat_of(7, 1, 1));
        send_frame(2, 9'h55, 7, 1'b1, 1'b1, 2'b11, 1);
        repeat (2 * CPB) @(negedge clk);

        // 8N2 with second stop bit low, then the line held low (break)
        push_exp(3, 9'hA5, 1'b1, 1'b0, 1'b0, lat_of(8, 0, 2));
        send_frame(3, 9'hA5, 8, 1'b0, 1'b0, 2'b01, 2);
        repeat (5 * CPB) @(negedge clk);
        check_val("break_busy", 32'(m_busy[3]), 32'd1);
        check_val("break_valid", 32'(m_valid[3]), 32'd0);
        rx_line[3] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_val("break_release_idle", 32'(m_busy[3]), 32'd0);
        push_exp(3, 9'h5A, 1'b0, 1'b0, 1'b0, lat_of(8, 0, 2));
        send_frame(3, 9'h5A, 8, 1'b0, 1'b0, 2'b11, 2);
        repeat (2 * CPB) @(negedge clk);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
